// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the calculator controller.
//               Holds the FSM state encoding, the ALU op code values and the
//               default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SW_W_DEF   = 16;

    // ALU op codes as produced by the button encoder
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_debounce.sv
`default_nettype none
// ============================================================================
// Module      : calc_debounce
// Description : One button input path: 2-flop synchroniser, consecutive-cycle
//               debounce counter, filtered level and rising-edge pulse.
// Ports       : clk, rst_n  - clock, async active-low reset
//               btn_i       - raw asynchronous button
//               level_o     - debounced level
//               rise_o      - one-cycle pulse on each 0->1 of level_o
// Revision    : 1.0 - initial release
// ============================================================================
module calc_debounce
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how many consecutive cycles the synchronised input
    // has disagreed with the filtered level; any agreeing cycle restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule
`default_nettype wire

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_ctrl
// Description : Sequencing controller for the button-driven calculator.
//               Debounces the five buttons, turns btnd/btnu presses into
//               execute/clear events and runs one ALU operation per press,
//               accumulating the result (mirrored on the LEDs).
// Ports       : clk, rst_n            - clock, async active-low reset
//               btnu/btnd             - clear / execute buttons (raw)
//               btnl/btnc/btnr        - op-select buttons (raw)
//               btn_f                 - debounced {btnl,btnc,btnr} to encoder
//               enc_op                - op code from encoder
//               sw                    - switch operand (sign-extended)
//               alu_result            - combinational ALU result
//               alu_op, op1, op2      - registered ALU op code and operands
//               led                   - accumulator[15:0]
//               busy                  - operation in flight
// Revision    : 1.0 - initial release
// ============================================================================
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int          DATA_W          = DATA_W_DEF,
    parameter int          SW_W            = SW_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btnu,
    input  logic              btnd,
    input  logic              btnl,
    input  logic              btnc,
    input  logic              btnr,
    output logic [2:0]        btn_f,
    input  logic [3:0]        enc_op,
    input  logic [SW_W-1:0]   sw,
    input  logic [DATA_W-1:0] alu_result,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [15:0]       led,
    output logic              busy
);

    // Button order: [4]=btnu, [3]=btnd, [2]=btnl, [1]=btnc, [0]=btnr
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_rise;
    logic [2:0] sel_rise_unused;
    logic       exec;
    logic       clr;

    assign btn_raw = {btnu, btnd, btnl, btnc, btnr};

    generate
        for (genvar i = 0; i < 5; i++) begin : g_btn
            calc_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_i   (btn_raw[i]),
                .level_o (btn_level[i]),
                .rise_o  (btn_rise[i])
            );
        end
    endgenerate

    assign btn_f           = btn_level[2:0];
    assign exec            = btn_rise[3];
    assign clr             = btn_rise[4];
    // Op-select buttons are consumed as levels by the encoder; their edges
    // have no use here.
    assign sel_rise_unused = btn_rise[2:0];

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [3:0]        op_q;
    logic [3:0]        op_d;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] opb_d;

    // Clear wins over everything: in IDLE it suppresses a simultaneous
    // execute, in ISSUE/CAPTURE it aborts the operation without capture.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        opb_d   = opb_q;
        if (clr) begin
            acc_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exec) begin
                        op_d    = enc_op;
                        opb_d   = DATA_W'($signed(sw));
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    acc_d   = alu_result;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
        end
    end

    // ALU inputs come straight from registers, so they stay stable across
    // the whole ISSUE/CAPTURE window and hold their values in IDLE.
    assign alu_op = op_q;
    assign op1    = acc_q;
    assign op2    = opb_q;
    assign led    = acc_q[15:0];
    assign busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_ctrl
// Description : Self-checking bench for calc_ctrl with a short debounce
//               window. Contains an ALU model and an accumulator reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;
    import calc_pkg::*;

    localparam int DW = 32;
    localparam int SWW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btnu, btnd, btnl, btnc, btnr;
    logic [2:0]  btn_f;
    logic [3:0]  enc_op;
    logic [15:0] sw;
    logic [31:0] alu_result;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2;
    logic [15:0] led;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          busy_cnt;
    logic [31:0] acc_m;

    always #5 clk = ~clk;

    calc_ctrl #(
        .DATA_W          (DW),
        .SW_W            (SWW),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnu       (btnu),
        .btnd       (btnd),
        .btnl       (btnl),
        .btnc       (btnc),
        .btnr       (btnr),
        .btn_f      (btn_f),
        .enc_op     (enc_op),
        .sw         (sw),
        .alu_result (alu_result),
        .alu_op     (alu_op),
        .op1        (op1),
        .op2        (op2),
        .led        (led),
        .busy       (busy)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    always_comb alu_result = ref_alu(alu_op, op1, op2);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (busy) busy_cnt++;
    endtask

    // One execute press; checks ISSUE operands, CAPTURE hold and T+3 result.
    task automatic do_op(input logic [3:0] op, input logic [15:0] swv, input int extra);
        bit          found;
        logic [31:0] exp;
        found  = 1'b0;
        enc_op = op;
        sw     = swv;
        btnd   = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy) begin
                found = 1'b1;
                break;
            end
        end
        check("exec_timeout", {31'd0, found}, 32'd1);
        if (found) begin
            check("issue_op1", op1, acc_m);
            check("issue_op2", op2, sext(swv));
            check("issue_aluop", {28'd0, alu_op}, {28'd0, op});
            exp = ref_alu(op, acc_m, sext(swv));
            @(negedge clk);
            check("capture_busy", {31'd0, busy}, 32'd1);
            check("capture_acc_old", op1, acc_m);
            @(negedge clk);
            check("done_busy", {31'd0, busy}, 32'd0);
            check("done_acc", op1, exp);
            check("done_led", {16'd0, led}, {16'd0, exp[15:0]});
            acc_m = exp;
        end
        busy_cnt = 0;
        repeat (extra) tick();
        btnd = 1'b0;
        repeat (14) tick();
        check("no_extra_op", busy_cnt, 0);
    endtask

    task automatic do_clr();
        btnu     = 1'b1;
        busy_cnt = 0;
        repeat (12) tick();
        check("clr_acc", op1, 32'd0);
        check("clr_led", {16'd0, led}, 32'd0);
        btnu = 1'b0;
        repeat (14) tick();
        check("clr_no_busy", busy_cnt, 0);
        acc_m = 32'd0;
    endtask

    typedef struct {
        bit          is_clr;
        logic [3:0]  op;
        logic [15:0] swv;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, OP_ADD, 16'h0000, 32'h0000_0000};
        tbl[1]  = '{1'b0, OP_ADD, 16'h0005, 32'h0000_0005};
        tbl[2]  = '{1'b0, OP_ADD, 16'hFFFF, 32'h0000_0004};
        tbl[3]  = '{1'b0, OP_SUB, 16'h0001, 32'h0000_0003};
        tbl[4]  = '{1'b1, OP_ADD, 16'h0000, 32'h0000_0000};
        tbl[5]  = '{1'b0, OP_ADD, 16'hFFFF, 32'hFFFF_FFFF};
        tbl[6]  = '{1'b0, OP_ADD, 16'h0001, 32'h0000_0000};
        tbl[7]  = '{1'b0, OP_ADD, 16'h7FFF, 32'h0000_7FFF};
        tbl[8]  = '{1'b0, OP_XOR, 16'h8000, 32'hFFFF_FFFF};
        tbl[9]  = '{1'b0, OP_AND, 16'h00F0, 32'h0000_00F0};
        tbl[10] = '{1'b0, OP_OR,  16'h0F0F, 32'h0000_0FFF};
        tbl[11] = '{1'b0, OP_SUB, 16'h1000, 32'hFFFF_FFFF};

        rst_n = 1'b0;
        {btnu, btnd, btnl, btnc, btnr} = 5'b0;
        enc_op   = OP_ADD;
        sw       = 16'h0;
        acc_m    = 32'd0;
        busy_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_acc", op1, 32'd0);
        check("rst_op2", op2, 32'd0);
        check("rst_aluop", {28'd0, alu_op}, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Op-select buttons reach btn_f filtered
        for (int b = 0; b < 3; b++) begin
            logic [2:0] pat;
            pat = 3'b001 << b;
            {btnl, btnc, btnr} = pat;
            repeat (10) @(negedge clk);
            check("btn_f_press", {29'd0, btn_f}, {29'd0, pat});
            {btnl, btnc, btnr} = 3'b000;
            repeat (10) @(negedge clk);
            check("btn_f_release", {29'd0, btn_f}, 32'd0);
        end

        // Table of sequential operations
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_clr) do_clr();
            else do_op(tbl[i].op, tbl[i].swv, 2);
            check("tbl_acc", op1, tbl[i].exp);
        end

        // Bounce: toggling faster than the debounce window produces one event
        do_clr();
        enc_op   = OP_ADD;
        sw       = 16'h0001;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            btnd = (i % 2 == 0);
            tick();
            tick();
        end
        btnd = 1'b1;
        repeat (20) tick();
        btnd = 1'b0;
        repeat (14) tick();
        check("bounce_busy", busy_cnt, 2);
        check("bounce_acc", op1, 32'd1);
        acc_m = 32'd1;

        // Hold: a long press yields exactly one operation
        busy_cnt = 0;
        btnd     = 1'b1;
        repeat (200) tick();
        btnd = 1'b0;
        repeat (14) tick();
        check("hold_busy", busy_cnt, 2);
        check("hold_acc", op1, 32'd2);
        acc_m = 32'd2;

        // Priority: clear and execute on the same cycle -> clear only
        do_clr();
        do_op(OP_ADD, 16'h0007, 0);
        busy_cnt = 0;
        btnu     = 1'b1;
        btnd     = 1'b1;
        repeat (12) tick();
        check("prio_acc", op1, 32'd0);
        check("prio_busy", busy_cnt, 0);
        btnu = 1'b0;
        btnd = 1'b0;
        repeat (14) tick();
        acc_m = 32'd0;

        // Clear landing in ISSUE aborts without capture
        do_op(OP_ADD, 16'h0007, 0);
        sw       = 16'h0003;
        busy_cnt = 0;
        btnd     = 1'b1;
        tick();
        btnu = 1'b1;
        repeat (15) tick();
        check("abort_acc", op1, 32'd0);
        check("abort_busy", busy_cnt, 1);
        btnu = 1'b0;
        btnd = 1'b0;
        repeat (14) tick();
        acc_m = 32'd0;

        // Asynchronous reset during CAPTURE with acc = 0x12
        do_op(OP_ADD, 16'h0012, 0);
        begin
            bit found;
            found = 1'b0;
            sw    = 16'h0001;
            btnd  = 1'b1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (busy) begin
                    found = 1'b1;
                    break;
                end
            end
            check("rst_exec_timeout", {31'd0, found}, 32'd1);
            @(negedge clk);
            check("rst_in_capture", {31'd0, busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("arst_acc", op1, 32'd0);
            check("arst_op2", op2, 32'd0);
            check("arst_aluop", {28'd0, alu_op}, 32'd0);
            check("arst_led", {16'd0, led}, 32'd0);
            check("arst_busy", {31'd0, busy}, 32'd0);
            check("arst_btnf", {29'd0, btn_f}, 32'd0);
            btnd = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            acc_m = 32'd0;
            repeat (14) @(negedge clk);
            check("arst_after", op1, 32'd0);
        end

        // Randomised operations against the accumulator reference
        for (int n = 0; n < 40; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) do_clr();
            else do_op(rop, 16'($urandom), int'($urandom_range(0, 20)));
            check("rand_acc", op1, acc_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
